// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction-fetch initiator: PC, one read per cycle, 2-entry {pc, insn} buffer
// Redirect flushes the buffer and any in-flight response; reset overrides everything.
module imem_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic [31:0] imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_insn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  // Slot 0 is always the head; slot 1 shifts into it on a pop from a full buffer.
  logic [31:0] s0_pc_q, s0_pc_d, s0_insn_q, s0_insn_d;
  logic [31:0] s1_pc_q, s1_pc_d, s1_insn_q, s1_insn_d;

  logic        deq;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  level;

  assign imem_address    = pc_q;
  assign imem_read_write = 32'd0;
  assign imem_data_in    = 32'd0;
  assign f_valid         = (count_q != 2'd0);
  assign f_pc            = s0_pc_q;
  assign f_insn          = s0_insn_q;

  always_comb begin
    deq       = f_valid & f_ready;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
    issue     = (occupancy < 3'd2) & ~redirect_valid;
    level     = count_q - {1'b0, deq};

    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    s0_pc_d       = s0_pc_q;
    s0_insn_d     = s0_insn_q;
    s1_pc_d       = s1_pc_q;
    s1_insn_d     = s1_insn_q;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end else begin
        inflight_d = 1'b0;
      end

      if (deq && (count_q == 2'd2)) begin
        s0_pc_d   = s1_pc_q;
        s0_insn_d = s1_insn_q;
      end

      // The issue rule guarantees a free slot whenever a response is in flight.
      if (inflight_q) begin
        if (level == 2'd0) begin
          s0_pc_d   = inflight_pc_q;
          s0_insn_d = imem_data_out;
        end else begin
          s1_pc_d   = inflight_pc_q;
          s1_insn_d = imem_data_out;
        end
      end

      count_d = level + {1'b0, inflight_q};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q          <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      s0_pc_q       <= 32'd0;
      s0_insn_q     <= 32'd0;
      s1_pc_q       <= 32'd0;
      s1_insn_q     <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      s0_pc_q       <= s0_pc_d;
      s0_insn_q     <= s0_insn_d;
      s1_pc_q       <= s1_pc_d;
      s1_insn_q     <= s1_insn_d;
    end
  end

endmodule
